// File: rtl/vmx_loader.sv
// Weight/vector loader feeding a chain of NUM_PE processing elements.
// Optional build macro VMX_LOADER_ZERO_BUBBLE_EN zeroes pe_data on every non-beat cycle.
module vmx_loader #(
    parameter int unsigned NUM_PE        = 8,
    parameter int unsigned VECTOR_BITLEN = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic                     run_start,
    input  logic                     cfg_simd,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [VECTOR_BITLEN-1:0] s_data,
    input  logic                     s_last,
    output logic                     pe_simd_mode,
    output logic [7:0]               pe_load_ctrl,
    output logic [VECTOR_BITLEN-1:0] pe_data,
    output logic                     vec_valid,
    output logic                     load_done,
    output logic                     busy
);

    localparam int unsigned CNT_W = 7;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PE - 1);
    localparam logic [7:0] CTRL_IDLE = 8'h7F;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     simd_q, simd_d;
    logic [7:0]               ctrl_q, ctrl_d;
    logic [VECTOR_BITLEN-1:0] data_q, data_d;
    logic                     vec_valid_q, vec_valid_d;
    logic                     load_done_q, load_done_d;
    logic                     busy_q, busy_d;
    logic                     ready_q, ready_d;
    logic                     accept;

    assign accept = s_valid & ready_q;

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        simd_d      = simd_q;
        ctrl_d      = CTRL_IDLE;
        vec_valid_d = 1'b0;
        load_done_d = 1'b0;
`ifdef VMX_LOADER_ZERO_BUBBLE_EN
        data_d      = '0;
`else
        data_d      = data_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else if (run_start) begin
                    state_d = ST_RUN;
                    simd_d  = cfg_simd;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    // Deepest PE first: hop count shrinks as beats are accepted
                    ctrl_d = {1'b1, LAST_IDX - cnt_q};
                    data_d = s_data;
                    if (cnt_q == LAST_IDX) begin
                        state_d     = ST_IDLE;
                        cnt_d       = '0;
                        load_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    data_d      = s_data;
                    vec_valid_d = 1'b1;
                    if (s_last) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            simd_q      <= 1'b0;
            ctrl_q      <= CTRL_IDLE;
            data_q      <= '0;
            vec_valid_q <= 1'b0;
            load_done_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            simd_q      <= simd_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            vec_valid_q <= vec_valid_d;
            load_done_q <= load_done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign s_ready      = ready_q;
    assign pe_simd_mode = simd_q;
    assign pe_load_ctrl = ctrl_q;
    assign pe_data      = data_q;
    assign vec_valid    = vec_valid_q;
    assign load_done    = load_done_q;
    assign busy         = busy_q;

endmodule

// File: doc/vmx_loader.md
VMX_LOADER -- requirements
Module: vmx_loader

Interface
REQ-001 The block SHALL have parameter NUM_PE, default 8, meaning the number of chained PEs fed (legal 1..127).
REQ-002 The block SHALL have parameter VECTOR_BITLEN, default 16, meaning the PE data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port load_start, input, 1 bit: pulse to begin a weight load.
REQ-006 The block SHALL have port run_start, input, 1 bit: pulse to begin a vector run.
REQ-007 The block SHALL have port cfg_simd, input, 1 bit: SIMD mode (1 = dual 8-bit), sampled on run_start.
REQ-008 The block SHALL have ports s_valid (in, 1), s_ready (out, 1), s_data (in, VECTOR_BITLEN) and s_last (in, 1): the input stream.
REQ-009 The block SHALL have port pe_simd_mode, output, 1 bit: the chain SIMD mode.
REQ-010 The block SHALL have port pe_load_ctrl, output, 8 bits: the chain load control.
REQ-011 The block SHALL have port pe_data, output, VECTOR_BITLEN bits: the chain data.
REQ-012 The block SHALL have ports vec_valid (out, 1: a vector beat is on pe_data), load_done (out, 1: pulse) and busy (out, 1: FSM not IDLE).

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, RUN and DRAIN.
REQ-014 IDLE->LOAD SHALL occur on load_start; IDLE->RUN on run_start; load_start SHALL win if both are asserted; both pulses SHALL be ignored outside IDLE.
REQ-015 s_ready SHALL be 1 only in LOAD and RUN; a beat is accepted when s_valid and s_ready are both 1.
REQ-016 In LOAD, the j-th accepted beat (j = 0..NUM_PE-1) SHALL drive pe_load_ctrl = 8'h80 + (NUM_PE-1-j) and pe_data = s_data, both registered, so they appear the cycle after acceptance.
REQ-017 Beat order SHALL be deepest PE first: beat 0 lands in PE NUM_PE-1 and beat NUM_PE-1 lands in PE0.
REQ-018 s_last SHALL be ignored in LOAD.
REQ-019 After NUM_PE beats, the FSM SHALL go LOAD->IDLE.
REQ-020 load_done SHALL pulse for 1 cycle coincident with the final load beat on the outputs; at the end of that cycle all PEs hold their weights, bubbles included.
REQ-021 Any non-load output cycle SHALL drive pe_load_ctrl = 8'h7F, which never decrements to 8'h80 within 127 hops.
REQ-022 A bubble (no acceptance in LOAD or RUN) SHALL NOT advance the beat counter.
REQ-023 In RUN, each accepted beat SHALL appear on pe_data the next cycle with vec_valid = 1; vec_valid SHALL be 0 otherwise.
REQ-024 pe_simd_mode SHALL hold the cfg_simd value latched at run_start until the next run_start; loads SHALL not change it.
REQ-025 An accepted beat with s_last = 1 in RUN SHALL cause RUN->DRAIN.
REQ-026 DRAIN SHALL last exactly NUM_PE cycles with s_ready = 0, then go to IDLE.
REQ-027 busy SHALL be 1 in LOAD, RUN and DRAIN, and 0 in IDLE.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, beat counter 0, pe_load_ctrl = 8'h7F, pe_data = 0, and pe_simd_mode, vec_valid, load_done, busy and s_ready all 0, including mid-LOAD or mid-RUN.
REQ-029 After an aborted load, partial weights remain in the PEs; a fresh load_start SHALL restart at beat 0.

Configuration
REQ-030 With macro VMX_LOADER_ZERO_BUBBLE_EN defined, pe_data SHALL be 0 on every bubble, IDLE and DRAIN cycle.
REQ-031 Without VMX_LOADER_ZERO_BUBBLE_EN, pe_data SHALL hold its last driven value on those cycles; pe_load_ctrl and vec_valid behaviour is identical in both builds.

Verification (NUM_PE=4)
REQ-032 load_start, then 4 back-to-back beats A,B,C,D -> pe_load_ctrl 83,82,81,80 with pe_data A,B,C,D on consecutive cycles; load_done with D; a 4-PE model holds PE3..PE0 = A..D.
REQ-033 Same load with a 2-cycle s_valid gap after B -> pe_load_ctrl 83,82,7F,7F,81,80; PE weights identical to REQ-032.
REQ-034 run_start with cfg_simd=1, then beats 0x0102, 0x0304 (s_last on the second) -> vec_valid for 2 cycles, pe_simd_mode=1, busy low exactly 4 cycles after the last beat.
REQ-035 load_start and run_start in the same cycle -> LOAD is entered and pe_simd_mode is unchanged.
REQ-036 rst_n asserted after 2 load beats -> outputs are at reset values within the same cycle; a new load of 4 beats produces 83..80.
REQ-037 Both builds, idle after a run ending in 0x0304 -> pe_data = 0 with VMX_LOADER_ZERO_BUBBLE_EN, 0x0304 without it.
